// File: rtl/tdc_readout_pkg.sv
// Shared definitions for the TDC readout: measurement word width, frame header
// and the framer state encoding.
package tdc_readout_pkg;

  localparam int COUNTER_DIG = 16;
  localparam int NUM_DECODE  = 4;
  localparam int DIG_OUT     = COUNTER_DIG + 2 * NUM_DECODE;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_DATA = 2'd2,
    ST_CHK  = 2'd3
  } rd_state_t;

  function automatic int num_bytes(input int w);
    return (w + 7) / 8;
  endfunction

endpackage

// File: rtl/tdc_fifo.sv
// Word FIFO between the TDC and the byte framer. Read data is combinational so
// the framer can take a word on the same edge it pops it.
module tdc_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Occupancy count decides full/empty; equal pointers alone are ambiguous.
  assign full    = (count_q == LW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr_q];
  assign level   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/tdc_readout.sv
// Buffers TDC measurement words and streams each one as a byte frame:
// header, word bytes MSB first, XOR checksum of the word bytes.
module tdc_readout
  import tdc_readout_pkg::*;
#(
  parameter int         W     = DIG_OUT,
  parameter int         DEPTH = 8,
  parameter logic [7:0] HDR   = HDR_BYTE
) (
  input  logic                   clk,
  input  logic                   irst,
  input  logic [W-1:0]           din,
  input  logic                   done,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic                   clr_ovf,
  output logic                   ovf,
  output logic [$clog2(DEPTH):0] level
);

  localparam int NB = num_bytes(W);
  localparam int SW = NB * 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  logic [W-1:0]  fifo_rdata;
  logic          fifo_full, fifo_empty;
  logic          pop, drop, xfer;
  logic [SW-1:0] padded, shifted;

  rd_state_t     state_q, state_d;
  logic [SW-1:0] shift_q, shift_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    chk_q, chk_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          ovf_q, ovf_d;

  tdc_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (irst),
    .push  (done),
    .pop   (pop),
    .wdata (din),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign xfer     = tx_valid_q && tx_ready;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign ovf      = ovf_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    chk_d      = chk_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    pop        = 1'b0;
    padded     = '0;
    padded[W-1:0] = fifo_rdata;
    shifted    = shift_q << 8;

    // Outputs are computed for the next state so tx_data/tx_valid come from flops.
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_d    = padded;
          chk_d      = '0;
          idx_d      = '0;
          state_d    = ST_HEAD;
          tx_valid_d = 1'b1;
          tx_data_d  = HDR;
        end
      end
      ST_HEAD: begin
        if (xfer) begin
          state_d   = ST_DATA;
          idx_d     = '0;
          tx_data_d = shift_q[SW-1 -: 8];
        end
      end
      ST_DATA: begin
        if (xfer) begin
          chk_d = chk_q ^ tx_data_q;
          if (idx_q == IW'(NB - 1)) begin
            state_d   = ST_CHK;
            tx_data_d = chk_q ^ tx_data_q;
          end else begin
            idx_d     = idx_q + IW'(1);
            shift_d   = shifted;
            tx_data_d = shifted[SW-1 -: 8];
          end
        end
      end
      ST_CHK: begin
        if (xfer) begin
          state_d    = ST_IDLE;
          tx_valid_d = 1'b0;
          tx_data_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A drop outranks a same-cycle clear so no lost word goes unreported.
    drop = done && fifo_full && !pop;
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  always_ff @(posedge clk or posedge irst) begin
    if (irst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      chk_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      chk_q      <= chk_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_tdc_readout.sv
// Randomized and directed checks of tdc_readout against a transaction-level
// model: a word queue plus the outstanding bytes of the frame in flight.
module tb_tdc_readout;

  localparam int W     = 24;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int NB    = (W + 7) / 8;
  localparam logic [7:0] HDR = 8'hA5;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          irst, done, tx_ready, clr_ovf;
  logic [W-1:0]  din;
  logic [7:0]    tx_data;
  logic          tx_valid, ovf;
  logic [LW-1:0] level;

  int n_total = 0;
  int n_bad   = 0;

  logic [W-1:0] m_q[$];
  bq_t          m_cur;
  logic [W-1:0] m_word;
  bit           m_ovf;
  bq_t          rx;

  always #5 clk = ~clk;

  tdc_readout #(
    .W     (W),
    .DEPTH (DEPTH),
    .HDR   (HDR)
  ) dut (
    .clk      (clk),
    .irst     (irst),
    .din      (din),
    .done     (done),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .clr_ovf  (clr_ovf),
    .ovf      (ovf),
    .level    (level)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Frame = header, zero-padded word bytes MSB first, XOR of those bytes.
  function automatic bq_t frame_of(input logic [W-1:0] w);
    bq_t            f;
    logic [8*NB-1:0] p;
    logic [7:0]     x;
    logic [7:0]     b;
    p = '0;
    p[W-1:0] = w;
    x = 8'h00;
    f.push_back(HDR);
    for (int i = NB - 1; i >= 0; i--) begin
      b = p[8*i +: 8];
      x = x ^ b;
      f.push_back(b);
    end
    f.push_back(x);
    return f;
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_cur.delete();
    m_ovf = 1'b0;
  endfunction

  // One clock: log the observed transfer, advance the model, then compare.
  task automatic tick();
    bit xfer, pop, full, acc, drop;
    if (tx_valid && tx_ready) rx.push_back(tx_data);
    xfer = (m_cur.size() > 0) && tx_ready;
    pop  = (m_cur.size() == 0) && (m_q.size() > 0);
    full = (m_q.size() == DEPTH);
    acc  = done && (!full || pop);
    drop = done && full && !pop;
    if (xfer) begin
      void'(m_cur.pop_front());
      if (m_cur.size() == 0) $display("frame sent: word=%h", m_word);
    end
    if (pop) begin
      m_word = m_q.pop_front();
      m_cur  = frame_of(m_word);
    end
    if (acc) m_q.push_back(din);
    if (drop)         m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
    @(posedge clk);
    #1;
    chk("tx_valid", 32'(tx_valid), 32'(m_cur.size() > 0));
    if (m_cur.size() > 0) chk("tx_data", 32'(tx_data), 32'(m_cur[0]));
    chk("level", 32'(level), 32'(m_q.size()));
    chk("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget && (m_cur.size() + m_q.size()) > 0; c++) tick();
    chk("drain", 32'(m_cur.size() + m_q.size()), 32'd0);
  endtask

  task automatic check_rx(input string tag, input bq_t e);
    chk({tag, "_len"}, 32'(rx.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < rx.size(); i++) chk(tag, 32'(rx[i]), 32'(e[i]));
  endtask

  initial begin
    bq_t e;
    irst = 1'b1; done = 1'b0; din = '0; tx_ready = 1'b0; clr_ovf = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_data",  32'(tx_data),  32'd0);
    chk("rst_level", 32'(level),    32'd0);
    chk("rst_ovf",   32'(ovf),      32'd0);
    // done during reset must not reach the FIFO
    done = 1'b1; din = 24'h111111;
    @(posedge clk); #1;
    chk("rst_done_ignored", 32'(level), 32'd0);
    irst = 1'b0; done = 1'b0;

    // Single word with latency check
    rx.delete();
    tx_ready = 1'b1; din = 24'h123456; done = 1'b1;
    tick();
    done = 1'b0;
    chk("lat_push_level", 32'(level), 32'd1);
    chk("lat_push_valid", 32'(tx_valid), 32'd0);
    tick();
    chk("lat_pop_valid", 32'(tx_valid), 32'd1);
    chk("lat_pop_hdr", 32'(tx_data), 32'hA5);
    chk("lat_pop_level", 32'(level), 32'd0);
    drain(50); tick(); tick();
    e = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h70};
    check_rx("single", e);

    // Backpressure: ready pattern 1,0,0 repeating
    rx.delete();
    din = 24'h123456;
    for (int c = 0; c < 60; c++) begin
      tx_ready = (c % 3 == 0);
      done     = (c == 0);
      tick();
    end
    done = 1'b0; tx_ready = 1'b1;
    drain(50);
    check_rx("backpressure", e);

    // Overflow: first word sits in the shift register, so nine words still fit
    rx.delete();
    tx_ready = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      din = W'(k); done = 1'b1;
      tick();
    end
    chk("ovf9_level", 32'(level), 32'd8);
    chk("ovf9_flag", 32'(ovf), 32'd0);
    din = W'(10);
    tick();
    chk("ovf10_level", 32'(level), 32'd8);
    chk("ovf10_flag", 32'(ovf), 32'd1);
    din = W'(11); clr_ovf = 1'b1;
    tick();
    chk("drop_beats_clear", 32'(ovf), 32'd1);
    done = 1'b0; clr_ovf = 1'b0;
    tick();
    chk("ovf_sticky", 32'(ovf), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(ovf), 32'd0);

    // Full FIFO, framer idle: push in the pop cycle is accepted
    tx_ready = 1'b1;
    for (int c = 0; c < 40 && m_cur.size() > 0; c++) tick();
    chk("full_before_simul", 32'(level), 32'd8);
    din = 24'h0000AA; done = 1'b1;
    tick();
    done = 1'b0;
    chk("simul_level", 32'(level), 32'd8);
    chk("simul_ovf", 32'(ovf), 32'd0);
    drain(400);
    e.delete();
    for (int k = 1; k <= 9; k++) e = {e, frame_of(W'(k))};
    e = {e, frame_of(24'h0000AA)};
    check_rx("ovf_stream", e);

    // Reset in the middle of a frame, with another word buffered
    rx.delete();
    tx_ready = 1'b1; din = 24'h123456; done = 1'b1;
    tick();
    din = 24'h777777;
    tick();
    done = 1'b0;
    for (int c = 0; c < 20 && rx.size() < 2; c++) tick();
    chk("rst_point_byte", 32'(rx.size() >= 2 ? rx[1] : 8'h00), 32'h12);
    irst = 1'b1; done = 1'b1;
    #1;
    chk("midrst_valid", 32'(tx_valid), 32'd0);
    chk("midrst_level", 32'(level), 32'd0);
    model_reset();
    @(posedge clk); #1;
    chk("midrst_done_ignored", 32'(level), 32'd0);
    irst = 1'b0; done = 1'b0;
    rx.delete();
    din = 24'hABCDEF; done = 1'b1;
    tick();
    done = 1'b0;
    drain(50); tick();
    e = '{8'hA5, 8'hAB, 8'hCD, 8'hEF, 8'h89};
    check_rx("after_rst", e);

    // Random traffic against the model
    rx.delete();
    for (int c = 0; c < 400; c++) begin
      done     = ($urandom_range(0, 2) == 0);
      din      = W'($urandom);
      tx_ready = $urandom_range(0, 1)[0];
      clr_ovf  = ($urandom_range(0, 15) == 0);
      tick();
    end
    done = 1'b0; clr_ovf = 1'b0; tx_ready = 1'b1;
    drain(500);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
